// File: rtl/uart_image_loader.sv
// rtl/uart_image_loader.sv - unpacks UART bytes into single-bit writes for the SNN input-spike memory
module uart_image_loader #(
  parameter int NUM_BITS    = 784,
  parameter int ADDR_W      = 10,
  parameter int TIMEOUT_CYC = 5000000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx_rdy,
  input  logic [7:0]        rx_data,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              wr_data,
  output logic              img_rdy,
  input  logic              img_ack,
  output logic              busy,
  output logic              overrun,
  output logic              frame_err
);

  localparam int                TO_W      = $clog2(TIMEOUT_CYC + 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_BITS - 1);
  localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [7:0]      shreg;
  logic [7:0]      hold_buf;
  logic            buf_full;
  logic [2:0]      bit_cnt;
  logic [6:0]      byte_cnt;
  logic [TO_W-1:0] to_cnt;

  logic last_bit;
  logic last_pix;
  logic load_next;
  logic to_run;
  logic to_hit;

  // event decode shared by the FSM and the datapath
  always_comb begin
    last_bit  = (state == S_SHIFT) && (bit_cnt == 3'd7);
    last_pix  = last_bit && (wr_addr == LAST_ADDR);
    // shreg takes the next byte: end of a non-final byte, or frame handed off
    load_next = (last_bit && !last_pix) || ((state == S_HOLD) && img_ack);
    // an arriving byte always wins over the timeout
    to_run    = (state == S_IDLE) && (byte_cnt != 7'd0) && !rx_rdy;
    to_hit    = to_run && (to_cnt == TO_LAST);
  end

  // state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (rx_rdy) state_nxt = S_SHIFT;
      end
      S_SHIFT: begin
        if (last_pix) begin
          state_nxt = S_HOLD;
        end else if (last_bit) begin
          state_nxt = (buf_full || rx_rdy) ? S_SHIFT : S_IDLE;
        end
      end
      S_HOLD: begin
        if (img_ack) state_nxt = (buf_full || rx_rdy) ? S_SHIFT : S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // output decode
  always_comb begin
    wr_en   = 1'b0;
    wr_data = 1'b0;
    img_rdy = 1'b0;
    busy    = buf_full;
    case (state)
      S_SHIFT: begin
        wr_en   = 1'b1;
        wr_data = shreg[bit_cnt];
        busy    = 1'b1;
      end
      S_HOLD: begin
        img_rdy = 1'b1;
        busy    = 1'b1;
      end
      default: ;
    endcase
  end

  // datapath: shift register, holding buffer, address/byte counters, timeout and sticky flags
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shreg     <= '0;
      hold_buf  <= '0;
      buf_full  <= 1'b0;
      bit_cnt   <= '0;
      byte_cnt  <= '0;
      wr_addr   <= '0;
      to_cnt    <= '0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      if (rx_rdy) to_cnt <= '0;

      case (state)
        S_IDLE: begin
          if (rx_rdy) begin
            shreg <= rx_data;
          end else if (to_hit) begin
            // drop the partial frame; memory keeps whatever was written
            frame_err <= 1'b1;
            wr_addr   <= '0;
            byte_cnt  <= '0;
            to_cnt    <= '0;
          end else if (to_run) begin
            to_cnt <= to_cnt + TO_W'(1);
          end
        end
        S_SHIFT: begin
          bit_cnt <= bit_cnt + 3'd1;
          // park on the last address while the frame waits for its ack
          if (!last_pix) wr_addr <= wr_addr + ADDR_W'(1);
          if (last_bit) byte_cnt <= byte_cnt + 7'd1;
        end
        S_HOLD: begin
          if (img_ack) begin
            wr_addr  <= '0;
            byte_cnt <= '0;
          end
        end
        default: ;
      endcase

      // holding buffer: one byte of look-ahead while shifting or holding a frame
      if (state != S_IDLE) begin
        if (load_next && buf_full) begin
          shreg    <= hold_buf;
          buf_full <= 1'b0;
          if (rx_rdy) overrun <= 1'b1;
        end else if (load_next && rx_rdy) begin
          shreg <= rx_data;
        end else if (rx_rdy) begin
          if (buf_full) begin
            overrun <= 1'b1;
          end else begin
            hold_buf <= rx_data;
            buf_full <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_image_loader.sv
// tb/tb_uart_image_loader.sv - directed table and sequence checks for uart_image_loader
module tb_uart_image_loader;

  localparam int ADDR_W = 10;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              rx_rdy;
  logic [7:0]        rx_data;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic              wr_data;
  logic              img_rdy;
  logic              img_ack;
  logic              busy;
  logic              overrun;
  logic              frame_err;

  int checks = 0;
  int errors = 0;

  uart_image_loader #(
    .NUM_BITS   (784),
    .ADDR_W     (ADDR_W),
    .TIMEOUT_CYC(100)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx_rdy   (rx_rdy),
    .rx_data  (rx_data),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .img_rdy  (img_rdy),
    .img_ack  (img_ack),
    .busy     (busy),
    .overrun  (overrun),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    string      seq;
    logic       ack_before;
  } vec_t;

  vec_t vecs[6];

  int obs_en[64];
  int obs_addr[64];
  int obs_data[64];
  int obs_ovr[64];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  function automatic logic bit_of(input string s, input int j);
    return (s[j] == 8'h31);
  endfunction

  task automatic do_reset();
    rst_n   = 1'b0;
    rx_rdy  = 1'b0;
    rx_data = 8'h00;
    img_ack = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  // pulse one byte from IDLE and watch its 8 writes; ends in the cycle of the 8th write
  task automatic run_byte(input logic [7:0] b, input int base, input string s, output int bad);
    bad     = 0;
    rx_data = b;
    rx_rdy  = 1'b1;
    step();
    rx_rdy = 1'b0;
    for (int j = 0; j < 8; j++) begin
      if (j > 0) step();
      if (wr_en !== 1'b1 || int'(wr_addr) != base + j || wr_data !== bit_of(s, j) || busy !== 1'b1)
        bad++;
    end
  endtask

  // 98 bytes of 0xFF with idle gaps; ends in the cycle of the write to address 783
  task automatic fill_frame(output int bad_total);
    int bad;
    bad_total = 0;
    for (int k = 0; k < 98; k++) begin
      run_byte(8'hFF, 8 * k, "11111111", bad);
      bad_total += bad;
      if (k < 97) repeat (4) step();
    end
  endtask

  // up to three rx pulses at cycle offsets 0, o1, o2; obs[c] is the cycle c+1 after the first pulse
  task automatic burst(input int n, input int o1, input int o2,
                       input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                       input int cycles);
    for (int c = 0; c < cycles; c++) begin
      rx_rdy = 1'b0;
      if (c == 0) begin
        rx_rdy = 1'b1; rx_data = b0;
      end else if (n > 1 && c == o1) begin
        rx_rdy = 1'b1; rx_data = b1;
      end else if (n > 2 && c == o2) begin
        rx_rdy = 1'b1; rx_data = b2;
      end
      step();
      obs_en[c]   = int'(wr_en);
      obs_addr[c] = int'(wr_addr);
      obs_data[c] = int'(wr_data);
      obs_ovr[c]  = int'(overrun);
    end
    rx_rdy = 1'b0;
  endtask

  task automatic check_burst(input string tag, input string s, input int cycles);
    int bad;
    int nwr;
    bad = 0;
    nwr = 0;
    for (int c = 0; c < cycles; c++) begin
      nwr += obs_en[c];
      if (c < 16) begin
        if (obs_en[c] != 1 || obs_addr[c] != c || obs_data[c] != int'(bit_of(s, c))) bad++;
      end
    end
    chk({tag, "_seq"}, bad, 0);
    chk({tag, "_count"}, nwr, 16);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  initial begin
    int bad;
    int bad_total;
    int fe_cnt;
    int fe_first;
    int fe_addr;
    int addr_before;

    vecs[0] = '{8'hA5, "10100101", 1'b0};
    vecs[1] = '{8'h01, "10000000", 1'b0};
    vecs[2] = '{8'h80, "00000001", 1'b1};
    vecs[3] = '{8'h3C, "00111100", 1'b0};
    vecs[4] = '{8'hFF, "11111111", 1'b0};
    vecs[5] = '{8'h00, "00000000", 1'b1};

    // reset state, sampled while rst_n is still low
    rst_n = 1'b0; rx_rdy = 1'b0; rx_data = 8'h00; img_ack = 1'b0;
    step(); step();
    chk("rst_wr_en", wr_en, 0);
    chk("rst_wr_addr", int'(wr_addr), 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_img_rdy", img_rdy, 0);
    chk("rst_busy", busy, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_frame_err", frame_err, 0);
    rst_n = 1'b1;

    // table: consecutive bytes land at 8k..8k+7, LSB first; stray img_ack is ignored
    for (int i = 0; i < 6; i++) begin
      if (vecs[i].ack_before) begin
        img_ack = 1'b1;
        step();
        img_ack = 1'b0;
      end
      run_byte(vecs[i].data, 8 * i, vecs[i].seq, bad);
      chk($sformatf("vec%0d_writes", i), bad, 0);
      step();
      chk($sformatf("vec%0d_idle_wr_en", i), wr_en, 0);
      chk($sformatf("vec%0d_idle_busy", i), busy, 0);
    end

    // full frame, HOLD, buffered byte, ack
    do_reset();
    fill_frame(bad_total);
    chk("frame_writes", bad_total, 0);
    step();
    chk("frame_img_rdy", img_rdy, 1);
    chk("frame_hold_wr_en", wr_en, 0);
    repeat (5) step();
    chk("frame_img_rdy_held", img_rdy, 1);
    rx_data = 8'h0F; rx_rdy = 1'b1;
    step();
    rx_rdy = 1'b0;
    chk("hold_buf_busy", busy, 1);
    chk("hold_buf_img_rdy", img_rdy, 1);
    img_ack = 1'b1;
    step();
    img_ack = 1'b0;
    chk("ack_img_rdy", img_rdy, 0);
    bad = 0;
    for (int j = 0; j < 8; j++) begin
      if (j > 0) step();
      if (wr_en !== 1'b1 || int'(wr_addr) != j || wr_data !== bit_of("11110000", j)) bad++;
    end
    chk("post_ack_writes", bad, 0);
    chk("post_ack_overrun", overrun, 0);

    // two pulses 3 cycles apart: 16 contiguous writes
    do_reset();
    burst(2, 3, 0, 8'h5A, 8'hC3, 8'h00, 24);
    check_burst("b2b", "0101101011000011", 24);
    chk("b2b_overrun", obs_ovr[23], 0);

    // three pulses within 8 cycles: third byte dropped, overrun sticky
    do_reset();
    burst(3, 2, 5, 8'h12, 8'h34, 8'h56, 24);
    check_burst("ovr", "0100100000101100", 24);
    chk("ovr_before_drop", obs_ovr[4], 0);
    chk("ovr_after_drop", obs_ovr[5], 1);
    repeat (30) step();
    run_byte(8'h01, 16, "10000000", bad);
    chk("ovr_next_byte", bad, 0);
    chk("ovr_sticky", overrun, 1);

    // partial-frame timeout with TIMEOUT_CYC=100
    do_reset();
    bad_total = 0;
    for (int k = 0; k < 5; k++) begin
      run_byte(8'h3C, 8 * k, "00111100", bad);
      bad_total += bad;
      if (k < 4) repeat (3) step();
    end
    chk("to_writes", bad_total, 0);
    fe_cnt = 0; fe_first = -1; fe_addr = -1; addr_before = -1;
    for (int k = 1; k <= 150; k++) begin
      step();
      if (k == 100) addr_before = int'(wr_addr);
      if (frame_err === 1'b1) begin
        fe_cnt++;
        if (fe_first < 0) begin
          fe_first = k;
          fe_addr  = int'(wr_addr);
        end
      end
    end
    chk("to_addr_before", addr_before, 40);
    chk("to_pulse_count", fe_cnt, 1);
    chk("to_pulse_cycle", fe_first, 101);
    chk("to_addr_cleared", fe_addr, 0);
    run_byte(8'hA5, 0, "10100101", bad);
    chk("to_next_byte", bad, 0);

    // reset during the 4th write with a byte buffered
    do_reset();
    rx_data = 8'hFF; rx_rdy = 1'b1;
    step();
    rx_data = 8'h00;
    step();
    rx_rdy = 1'b0;
    step(); step();
    chk("mid_pre_wr_addr", int'(wr_addr), 3);
    rst_n = 1'b0;
    step();
    chk("mid_rst_wr_en", wr_en, 0);
    chk("mid_rst_wr_addr", int'(wr_addr), 0);
    chk("mid_rst_wr_data", wr_data, 0);
    chk("mid_rst_busy", busy, 0);
    rst_n = 1'b1;
    run_byte(8'hA5, 0, "10100101", bad);
    chk("mid_next_byte", bad, 0);
    step();
    chk("mid_no_extra_write", wr_en, 0);

    // reset while in HOLD with a byte buffered
    do_reset();
    fill_frame(bad_total);
    chk("frame2_writes", bad_total, 0);
    step();
    chk("frame2_img_rdy", img_rdy, 1);
    rx_data = 8'h55; rx_rdy = 1'b1;
    step();
    rx_rdy = 1'b0;
    rst_n = 1'b0;
    step();
    chk("hold_rst_img_rdy", img_rdy, 0);
    chk("hold_rst_busy", busy, 0);
    chk("hold_rst_wr_addr", int'(wr_addr), 0);
    chk("hold_rst_wr_en", wr_en, 0);
    rst_n = 1'b1;
    run_byte(8'h80, 0, "00000001", bad);
    chk("hold_next_byte", bad, 0);
    step();
    chk("hold_no_extra_write", wr_en, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
